// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, fixed wait states, one-cycle response.
// Optional misaligned-address checking is enabled with `define DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    mis_q;

  logic [31:0]             mem [DEPTH];

  logic                    req_mis;
  logic                    from_idle;
  logic                    enter_resp;
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_mis;

`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr;
  assign req_mis     = (req_addr[1:0] != 2'b00);
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
`else
  logic unused_addr;
  assign req_mis     = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`endif

  // With zero wait states the access happens on the accepting edge, so use the live request
  assign from_idle  = (state_q == ST_IDLE);
  assign acc_write  = from_idle ? req_write : wr_q;
  assign acc_idx    = from_idle ? req_addr[ADDR_WIDTH+1:2] : idx_q;
  assign acc_wdata  = from_idle ? req_wdata : wdata_q;
  assign acc_be     = from_idle ? req_byte_en : be_q;
  assign acc_mis    = from_idle ? req_mis : mis_q;
  assign enter_resp = (state_d == ST_RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counter, handshake and stall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      mis_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (from_idle && req_valid) begin
        wr_q    <= req_write;
        idx_q   <= req_addr[ADDR_WIDTH+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_byte_en;
        mis_q   <= req_mis;
      end
      resp_valid <= enter_resp;
      resp_err   <= enter_resp && acc_mis;
      if (enter_resp && !acc_write && !acc_mis) begin
        resp_rdata <= mem[acc_idx];
      end else begin
        resp_rdata <= '0;
      end
    end
  end

  // Byte-lane writes; array contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_write && !acc_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
